// File: rtl/dm_stack_mem.sv
// dm_stack_mem: data memory with load/store at an explicit address and
// push/pop through an internal, downward-growing stack pointer.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   load, store      read / write mem[addr]
//   push, pop        write val to stack / read top of stack
//   addr, val        load/store address, store/push data
//   err_clr          synchronous clear of the sticky error flags
//   out, out_valid   registered read data and its one-cycle strobe
//   sp               stack pointer (ADDR_W+1 bits, STACK_TOP when empty)
//   err_ovf/unf/ill  sticky overflow, underflow, multi-op errors
//   err_grd          sticky guard error (only with DM_STACK_GUARD_EN)
//
// Build option: define DM_STACK_GUARD_EN to block load/store accesses
// that fall inside the stack region [STACK_LIMIT, STACK_TOP).

module dm_stack_mem #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int STACK_TOP   = 2 ** ADDR_W,
    parameter int STACK_LIMIT = 192
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              store,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] val,
    input  logic              err_clr,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic [ADDR_W:0]   sp,
`ifdef DM_STACK_GUARD_EN
    output logic              err_grd,
`endif
    output logic              err_ovf,
    output logic              err_unf,
    output logic              err_ill
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int SPW   = ADDR_W + 1;

    localparam logic [SPW-1:0] SP_TOP = SPW'(STACK_TOP);
    localparam logic [SPW-1:0] SP_LIM = SPW'(STACK_LIMIT);

    // Storage (deliberately not reset)
    logic [DATA_W-1:0] mem_q [DEPTH];

    // Registered state
    logic [DATA_W-1:0] out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic [SPW-1:0]    sp_q, sp_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ill_q, ill_d;
    logic              grd_q, grd_d;

    // Per-cycle decode
    logic              op_ill;
    logic              set_ovf;
    logic              set_unf;
    logic              set_ill;
    logic              set_grd;
    logic              guard_hit;
    logic              stk_full;
    logic              stk_empty;
    logic [SPW-1:0]    sp_dec;
    logic [SPW-1:0]    sp_inc;
    logic [SPW-1:0]    addr_ext;

    // Write port
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Any pair of ops asserted together makes the cycle illegal.
    assign op_ill = (load  & store) | (load  & push) | (load  & pop)
                  | (store & push)  | (store & pop)  | (push  & pop);

    assign sp_dec    = sp_q - SPW'(1);
    assign sp_inc    = sp_q + SPW'(1);
    assign stk_full  = (sp_q <= SP_LIM);
    assign stk_empty = (sp_q >= SP_TOP);
    assign addr_ext  = {1'b0, addr};

`ifdef DM_STACK_GUARD_EN
    assign guard_hit = (addr_ext >= SP_LIM) && (addr_ext < SP_TOP);
`else
    assign guard_hit = 1'b0;
`endif

    always_comb begin
        out_d       = out_q;
        out_valid_d = 1'b0;
        sp_d        = sp_q;
        set_ovf     = 1'b0;
        set_unf     = 1'b0;
        set_ill     = 1'b0;
        set_grd     = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = addr;
        mem_wdata   = val;

        if (op_ill) begin
            set_ill = 1'b1;
        end else if (load) begin
            out_valid_d = 1'b1;
            if (guard_hit) begin
                out_d   = '0;
                set_grd = 1'b1;
            end else begin
                out_d = mem_q[addr];
            end
        end else if (store) begin
            if (guard_hit) begin
                set_grd = 1'b1;
            end else begin
                mem_we = 1'b1;
            end
        end else if (push) begin
            if (stk_full) begin
                set_ovf = 1'b1;
            end else begin
                mem_we    = 1'b1;
                mem_waddr = sp_dec[ADDR_W-1:0];
                sp_d      = sp_dec;
            end
        end else if (pop) begin
            if (stk_empty) begin
                set_unf = 1'b1;
            end else begin
                out_d       = mem_q[sp_q[ADDR_W-1:0]];
                out_valid_d = 1'b1;
                sp_d        = sp_inc;
            end
        end
    end

    // Sticky flags: a new error in the clearing cycle keeps the flag set.
    always_comb begin
        ovf_d = set_ovf | (ovf_q & ~err_clr);
        unf_d = set_unf | (unf_q & ~err_clr);
        ill_d = set_ill | (ill_q & ~err_clr);
        grd_d = set_grd | (grd_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            sp_q        <= SP_TOP;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            ill_q       <= 1'b0;
            grd_q       <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            sp_q        <= sp_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            ill_q       <= ill_d;
            grd_q       <= grd_d;
        end
    end

    // Gating with rst_n drops the write of a cycle interrupted by reset.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign sp        = sp_q;
    assign err_ovf   = ovf_q;
    assign err_unf   = unf_q;
    assign err_ill   = ill_q;

`ifdef DM_STACK_GUARD_EN
    assign err_grd = grd_q;
`else
    logic unused_grd;
    assign unused_grd = grd_q;
`endif

endmodule

// File: tb/tb_dm_stack_mem.sv
// tb_dm_stack_mem: randomized self-checking bench for dm_stack_mem,
// compared against a memory-array plus stack-queue reference model.

module tb_dm_stack_mem;

    localparam int LIM = 252;
    localparam int TOP = 256;
    localparam int CAP = TOP - LIM;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic        store = 1'b0;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] val = '0;
    logic        err_clr = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic [8:0]  sp;
    logic        err_ovf;
    logic        err_unf;
    logic        err_ill;
    logic        grd_w;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dm_stack_mem #(
        .DATA_W(16),
        .ADDR_W(8),
        .STACK_TOP(TOP),
        .STACK_LIMIT(LIM)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .load(load),
        .store(store),
        .push(push),
        .pop(pop),
        .addr(addr),
        .val(val),
        .err_clr(err_clr),
        .out(out),
        .out_valid(out_valid),
        .sp(sp),
`ifdef DM_STACK_GUARD_EN
        .err_grd(grd_w),
`endif
        .err_ovf(err_ovf),
        .err_unf(err_unf),
        .err_ill(err_ill)
    );

`ifndef DM_STACK_GUARD_EN
    assign grd_w = 1'b0;
`endif

    // Reference model: flat memory for load/store, a queue for the stack.
    logic [15:0] m_mem [256];
    logic [15:0] stk [$];
    logic [15:0] m_out;
    logic        m_valid;
    logic        m_ovf, m_unf, m_ill, m_grd;

    function automatic logic [29:0] obs_vec();
        return {out, out_valid, sp, err_ovf, err_unf, err_ill, grd_w};
    endfunction

    function automatic logic [29:0] exp_vec();
        logic [8:0] esp;
        esp = 9'(TOP - stk.size());
        return {m_out, m_valid, esp, m_ovf, m_unf, m_ill, m_grd};
    endfunction

    task automatic mdl_reset();
        stk.delete();
        m_out   = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_ill   = 1'b0;
        m_grd   = 1'b0;
    endtask

    task automatic mdl(input logic l, input logic s, input logic pu,
                       input logic po, input logic [7:0] a,
                       input logic [15:0] v, input logic clr);
        int n;
        bit so, su, si, sg, in_stk;
        n  = int'(l) + int'(s) + int'(pu) + int'(po);
        so = 0; su = 0; si = 0; sg = 0;
`ifdef DM_STACK_GUARD_EN
        in_stk = (int'(a) >= LIM) && (int'(a) < TOP);
`else
        in_stk = 0;
`endif
        m_valid = 1'b0;
        if (n > 1) begin
            si = 1;
        end else if (l) begin
            m_valid = 1'b1;
            if (in_stk) begin
                m_out = '0;
                sg = 1;
            end else begin
                m_out = m_mem[a];
            end
        end else if (s) begin
            if (in_stk) sg = 1;
            else m_mem[a] = v;
        end else if (pu) begin
            if (stk.size() < CAP) stk.push_back(v);
            else so = 1;
        end else if (po) begin
            if (stk.size() > 0) begin
                m_out = stk.pop_back();
                m_valid = 1'b1;
            end else begin
                su = 1;
            end
        end
        m_ovf = so | (m_ovf & ~clr);
        m_unf = su | (m_unf & ~clr);
        m_ill = si | (m_ill & ~clr);
        m_grd = sg | (m_grd & ~clr);
    endtask

    task automatic cyc(input logic l, input logic s, input logic pu,
                       input logic po, input logic [7:0] a,
                       input logic [15:0] v, input logic clr);
        load = l; store = s; push = pu; pop = po;
        addr = a; val = v; err_clr = clr;
        @(posedge clk);
        #1;
        load = 0; store = 0; push = 0; pop = 0; err_clr = 0;
        mdl(l, s, pu, po, a, v, clr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", obs_vec(), exp_vec());
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 8'h00, 16'h0, 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL reset_idle%0d got=%h exp=%h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_init();
        for (int i = 0; i < LIM; i++) begin
            cyc(0, 1, 0, 0, 8'(i), 16'($urandom), 0);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL init got=%h exp=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_store_load();
        cyc(0, 1, 0, 0, 8'h10, 16'hBEEF, 0);
        cyc(1, 0, 0, 0, 8'h10, 16'h0, 0);
        checks++;
        if (out !== 16'hBEEF || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL store_load out=%h v=%b exp=beef v=1",
                     out, out_valid);
        end
        cyc(0, 0, 0, 0, 8'h00, 16'h0, 0);
        checks++;
        if (obs_vec() !== exp_vec() || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe got=%h exp=%h",
                     obs_vec(), exp_vec());
        end
    endtask

    task automatic test_push_pop();
        logic [15:0] pv [3];
        pv[0] = 16'h1111; pv[1] = 16'h2222; pv[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 1, 0, 8'h00, pv[i], 0);
            checks++;
            if (sp !== 9'(255 - i) || obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL push%0d sp=%0d exp=%0d got=%h exp=%h",
                         i, sp, 255 - i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 8'h00, 16'h0, 0);
            checks++;
            if (out !== pv[2-i] || out_valid !== 1'b1 ||
                obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL pop%0d out=%h exp=%h got=%h exp=%h",
                         i, out, pv[2-i], obs_vec(), exp_vec());
            end
        end
        checks++;
        if (sp !== 9'd256) begin
            errors++;
            $display("FAIL pop_sp sp=%0d exp=256", sp);
        end
    endtask

    task automatic test_ovf_unf();
        logic [15:0] keep;
        keep = m_mem[251];
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 1, 0, 8'h00, 16'(16'hA000 + i), 0);
        checks++;
        if (sp !== 9'd252 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL full sp=%0d ovf=%b exp 252/0", sp, err_ovf);
        end
        cyc(0, 0, 1, 0, 8'h00, 16'hDEAD, 0);
        checks++;
        if (sp !== 9'd252 || err_ovf !== 1'b1 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ovf sp=%0d ovf=%b exp 252/1", sp, err_ovf);
        end
        cyc(1, 0, 0, 0, 8'd251, 16'h0, 0);
        checks++;
        if (out !== keep) begin
            errors++;
            $display("FAIL ovf_nowrite out=%h exp=%h", out, keep);
        end
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 1, 8'h00, 16'h0, 0);
        checks++;
        if (err_unf !== 1'b1 || sp !== 9'd256 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL unf got=%h exp=%h", obs_vec(), exp_vec());
        end
        cyc(0, 0, 0, 0, 8'h00, 16'h0, 1);
        checks++;
        if (err_ovf !== 1'b0 || err_unf !== 1'b0 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL err_clr got=%h exp=%h", obs_vec(), exp_vec());
        end
        // Clear and a new error together: the flag stays set.
        cyc(0, 0, 0, 1, 8'h00, 16'h0, 1);
        checks++;
        if (err_unf !== 1'b1) begin
            errors++;
            $display("FAIL clr_set_wins unf=%b exp=1", err_unf);
        end
        cyc(0, 0, 0, 0, 8'h00, 16'h0, 1);
    endtask

    task automatic test_illegal();
        logic [15:0] keep;
        keep = m_mem[8'h20];
        cyc(1, 1, 0, 0, 8'h20, 16'h5555, 0);
        checks++;
        if (err_ill !== 1'b1 || out_valid !== 1'b0 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL ill got=%h exp=%h", obs_vec(), exp_vec());
        end
        cyc(1, 0, 0, 0, 8'h20, 16'h0, 1);
        checks++;
        if (out !== keep || err_ill !== 1'b0) begin
            errors++;
            $display("FAIL ill_nowrite out=%h exp=%h ill=%b",
                     out, keep, err_ill);
        end
    endtask

    task automatic test_reset_mid_op();
`ifndef DM_STACK_GUARD_EN
        cyc(0, 1, 0, 0, 8'd254, 16'h7777, 0);
`endif
        cyc(0, 0, 1, 0, 8'h00, 16'h1234, 0);
        push = 1'b1;
        val  = 16'hDEAD;
        #2;
        rst_n = 1'b0;
        #1;
        mdl_reset();
        checks++;
        if (sp !== 9'd256 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rst_mid sp=%0d got=%h exp=%h",
                     sp, obs_vec(), exp_vec());
        end
        @(posedge clk);
        #1;
        push  = 1'b0;
        rst_n = 1'b1;
`ifndef DM_STACK_GUARD_EN
        cyc(1, 0, 0, 0, 8'd254, 16'h0, 0);
        checks++;
        if (out !== 16'h7777) begin
            errors++;
            $display("FAIL rst_nowrite out=%h exp=7777", out);
        end
`endif
    endtask

    task automatic test_random();
        logic l, s, pu, po, clr;
        int r;
        for (int i = 0; i < 400; i++) begin
            l = 0; s = 0; pu = 0; po = 0;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: l = 1;
                2, 3: s = 1;
                4, 5: pu = 1;
                6, 7: po = 1;
                9: begin
                    l  = 1'($urandom);
                    s  = 1'($urandom);
                    pu = ~l;
                    po = ~s;
                end
                default: ;
            endcase
            clr = ($urandom_range(0, 7) == 0);
            cyc(l, s, pu, po, 8'($urandom_range(0, LIM - 1)),
                16'($urandom), clr);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand%0d got=%h exp=%h",
                         i, obs_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_guard();
`ifdef DM_STACK_GUARD_EN
        cyc(0, 0, 0, 0, 8'h00, 16'h0, 1);
        cyc(0, 1, 0, 0, 8'hFD, 16'hAAAA, 0);
        checks++;
        if (grd_w !== 1'b1 || obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL grd_store got=%h exp=%h", obs_vec(), exp_vec());
        end
        cyc(1, 0, 0, 0, 8'hFD, 16'h0, 0);
        checks++;
        if (out !== 16'h0 || out_valid !== 1'b1 ||
            obs_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL grd_load got=%h exp=%h", obs_vec(), exp_vec());
        end
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        mdl_reset();
        test_reset();
        test_init();
        test_store_load();
        test_push_pop();
        test_ovf_unf();
        test_illegal();
        test_reset_mid_op();
        test_random();
        test_guard();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
